hex_display_feed: RTL and testbench

- Source stage for the two-digit seven-segment mux. Accepts an 8-bit value on a load strobe and holds it in a shadow register.
- Commits the shadow value to two registered segment patterns only at refresh-frame boundaries, so the display never tears mid-frame.
- Generates the refresh select (`divided_clk`) that the display mux uses to alternate digits; `disp0` shows the low nibble and `disp1` the high nibble.

---
 rtl/hex_display_feed_if.sv | 23 ++
 rtl/hex_display_feed.sv | 96 +++++++++
 tb/tb_hex_display_feed.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/hex_display_feed_if.sv
// Interface bundle for hex_display_feed: byte/strobe/control inputs towards
// the feed, registered segment patterns and refresh status back to the mux.
interface hex_display_feed_if;
  logic [7:0] value;
  logic       load;
  logic       en;
  logic       blank_lz;
  logic [6:0] disp0;
  logic [6:0] disp1;
  logic       divided_clk;
  logic       frame_tick;
  logic       pending;

  modport master (
    output value, load, en, blank_lz,
    input  disp0, disp1, divided_clk, frame_tick, pending
  );

  modport slave (
    input  value, load, en, blank_lz,
    output disp0, disp1, divided_clk, frame_tick, pending
  );
endinterface

// File: rtl/hex_display_feed.sv
// Source stage for a two-digit seven-segment mux: shadows a loaded byte and
// commits it to registered segment patterns only at refresh-frame wraps.
module hex_display_feed #(
  parameter int unsigned DIV_BITS       = 16,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input logic               clk,
  input logic               rst_n,
  hex_display_feed_if.slave bus
);

  localparam logic [6:0] SEG_POL = {7{SEG_ACTIVE_LOW}};
  localparam logic [6:0] BLANK   = SEG_POL;

  logic [DIV_BITS-1:0] cnt_q, cnt_d;
  logic [7:0]          shadow_q, shadow_d;
  logic [7:0]          committed_q, committed_d;
  logic                pending_q, pending_d;
  logic [6:0]          disp0_q, disp0_d;
  logic [6:0]          disp1_q, disp1_d;
  logic                tick_q, tick_d;
  logic                wrap;
  logic [7:0]          src;
  logic                hi_blank;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] seg;
    seg = '0;
    unique case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
    endcase
    return seg;
  endfunction

  // Next-state: prescaler, shadow capture, and frame-boundary commit.
  // A load on the wrap cycle bypasses the shadow; a wrap with nothing
  // pending re-decodes the committed byte so blank_lz changes take effect.
  always_comb begin
    wrap        = bus.en && (cnt_q == '1);
    cnt_d       = bus.en ? cnt_q + DIV_BITS'(1) : cnt_q;
    src         = bus.load ? bus.value : (pending_q ? shadow_q : committed_q);
    hi_blank    = bus.blank_lz && (src[7:4] == 4'h0);
    shadow_d    = bus.load ? bus.value : shadow_q;
    pending_d   = wrap ? 1'b0 : (bus.load ? 1'b1 : pending_q);
    committed_d = wrap ? src : committed_q;
    disp0_d     = wrap ? (decode(src[3:0]) ^ SEG_POL) : disp0_q;
    disp1_d     = disp1_q;
    if (wrap) begin
      disp1_d = hi_blank ? BLANK : (decode(src[7:4]) ^ SEG_POL);
    end
    tick_d      = wrap;
  end

  // State registers with asynchronous active-low reset to a blank display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      shadow_q    <= '0;
      committed_q <= '0;
      pending_q   <= 1'b0;
      disp0_q     <= BLANK;
      disp1_q     <= BLANK;
      tick_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      committed_q <= committed_d;
      pending_q   <= pending_d;
      disp0_q     <= disp0_d;
      disp1_q     <= disp1_d;
      tick_q      <= tick_d;
    end
  end

  assign bus.disp0       = disp0_q;
  assign bus.disp1       = disp1_q;
  assign bus.divided_clk = cnt_q[DIV_BITS-1];
  assign bus.frame_tick  = tick_q;
  assign bus.pending     = pending_q;

endmodule

// File: tb/tb_hex_display_feed.sv
// Self-checking bench for hex_display_feed with a 16-cycle refresh frame.
module tb_hex_display_feed;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  hex_display_feed_if bus ();

  hex_display_feed #(.DIV_BITS(4), .SEG_ACTIVE_LOW(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Behavioural model: frame position, last byte shown and its blanking flag.
  int         m_cnt;
  logic [7:0] m_shadow, m_comm;
  bit         m_pend, m_shown, m_lz, m_tick;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_shadow = 8'h00; m_comm = 8'h00;
      m_pend = 0; m_shown = 0; m_lz = 0; m_tick = 0;
    end else begin
      m_tick = 0;
      if (bus.en && m_cnt == 15) begin
        if (bus.load)  m_comm = bus.value;
        else if (m_pend) m_comm = m_shadow;
        if (bus.load)  m_shadow = bus.value;
        m_lz = bus.blank_lz; m_shown = 1; m_tick = 1; m_pend = 0;
      end else if (bus.load) begin
        m_shadow = bus.value; m_pend = 1;
      end
      if (bus.en) m_cnt = (m_cnt + 1) % 16;
    end
  end

  function automatic logic [6:0] exp_d0();
    return m_shown ? SEG[m_comm[3:0]] : 7'h00;
  endfunction

  function automatic logic [6:0] exp_d1();
    if (!m_shown) return 7'h00;
    if (m_lz && m_comm[7:4] == 4'h0) return 7'h00;
    return SEG[m_comm[7:4]];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("disp0", 32'(bus.disp0), 32'(exp_d0()));
    chk("disp1", 32'(bus.disp1), 32'(exp_d1()));
    chk("frame_tick", 32'(bus.frame_tick), 32'(m_tick));
    chk("pending", 32'(bus.pending), 32'(m_pend));
    chk("divided_clk", 32'(bus.divided_clk), 32'(m_cnt >= 8));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input int n);
    int guard = 0;
    while (m_cnt != n && guard < 40) begin
      step();
      guard++;
    end
    if (m_cnt != n) begin
      n_cmp++; n_bad++;
      $display("FAIL go_to timeout: cnt %0d expected %0d", m_cnt, n);
    end
  endtask

  task automatic load_byte(input logic [7:0] v);
    bus.value = v;
    bus.load  = 1'b1;
    step();
    bus.load  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.value = 8'h00; bus.load = 1'b0; bus.en = 1'b0; bus.blank_lz = 1'b0;
    #1;
    chk("rst_disp0", 32'(bus.disp0), 32'h00);
    repeat (3) step();
    rst_n  = 1'b1;
    bus.en = 1'b1;

    // 1: blank until first wrap, then "00"; 50% duty refresh select
    for (int k = 1; k <= 17; k++) begin
      step();
      if (k == 7)  chk("s1_divclk_lo", 32'(bus.divided_clk), 32'h0);
      if (k == 8)  chk("s1_divclk_hi", 32'(bus.divided_clk), 32'h1);
      if (k == 15) chk("s1_blank", 32'(bus.disp0), 32'h00);
      if (k == 16) begin
        chk("s1_disp0", 32'(bus.disp0), 32'h3F);
        chk("s1_disp1", 32'(bus.disp1), 32'h3F);
        chk("s1_tick", 32'(bus.frame_tick), 32'h1);
      end
      if (k == 17) chk("s1_tick_end", 32'(bus.frame_tick), 32'h0);
    end

    // 2: load A5 mid-frame
    go_to(3);
    load_byte(8'hA5);
    chk("s2_pending", 32'(bus.pending), 32'h1);
    go_to(0);
    chk("s2_disp0", 32'(bus.disp0), 32'h6D);
    chk("s2_disp1", 32'(bus.disp1), 32'h77);
    chk("s2_pending_clr", 32'(bus.pending), 32'h0);

    // 3: last load before the wrap wins
    go_to(2);
    load_byte(8'h12);
    go_to(9);
    load_byte(8'h9C);
    go_to(0);
    chk("s3_disp0", 32'(bus.disp0), 32'h39);
    chk("s3_disp1", 32'(bus.disp1), 32'h6F);

    // 4: load on the wrap cycle bypasses the shadow
    go_to(15);
    load_byte(8'h07);
    chk("s4_disp0", 32'(bus.disp0), 32'h07);
    chk("s4_disp1", 32'(bus.disp1), 32'h3F);
    chk("s4_pending", 32'(bus.pending), 32'h0);
    chk("s4_tick", 32'(bus.frame_tick), 32'h1);
    go_to(15);
    bus.blank_lz = 1'b1;
    load_byte(8'h07);
    chk("s4_lz_disp1", 32'(bus.disp1), 32'h00);
    chk("s4_lz_disp0", 32'(bus.disp0), 32'h07);
    bus.blank_lz = 1'b0;

    // 5: freeze with en=0, load still captured
    go_to(6);
    bus.en = 1'b0;
    load_byte(8'h3E);
    repeat (40) step();
    chk("s5_pending", 32'(bus.pending), 32'h1);
    chk("s5_divclk", 32'(bus.divided_clk), 32'h0);
    chk("s5_disp0", 32'(bus.disp0), 32'h07);
    chk("s5_disp1", 32'(bus.disp1), 32'h00);
    chk("s5_tick", 32'(bus.frame_tick), 32'h0);
    bus.en = 1'b1;
    repeat (9) step();
    chk("s5_hold", 32'(bus.disp0), 32'h07);
    step();
    chk("s5_disp0", 32'(bus.disp0), 32'h79);
    chk("s5_disp1", 32'(bus.disp1), 32'h4F);

    // 6: asynchronous reset mid-frame discards the pending byte
    go_to(2);
    load_byte(8'hFF);
    go_to(5);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_disp0", 32'(bus.disp0), 32'h00);
    chk("s6_disp1", 32'(bus.disp1), 32'h00);
    chk("s6_pending", 32'(bus.pending), 32'h0);
    chk("s6_divclk", 32'(bus.divided_clk), 32'h0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (16) step();
    chk("s6_disp0_after", 32'(bus.disp0), 32'h3F);
    chk("s6_disp1_after", 32'(bus.disp1), 32'h3F);
    chk("s6_tick_after", 32'(bus.frame_tick), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
